// File: rtl/instr_fetch_decode_pkg.sv
// Shared PDP-8 fetch/decode definitions.
//  - Word and address widths and the default start address.
//  - Memory-reference opcode field values (bits [11:9]).
//  - Full-word encodings of the supported group-7 operate instructions.
//  - One-hot decoded opcode structs driven by the fetch/decode unit.
package instr_fetch_decode_pkg;

  localparam int DATA_WIDTH = 12;
  localparam int ADDR_WIDTH = 12;
  localparam logic [ADDR_WIDTH-1:0] START_ADDRESS = 12'o0200;

  localparam logic [2:0] OP_AND = 3'o0;
  localparam logic [2:0] OP_TAD = 3'o1;
  localparam logic [2:0] OP_ISZ = 3'o2;
  localparam logic [2:0] OP_DCA = 3'o3;
  localparam logic [2:0] OP_JMS = 3'o4;
  localparam logic [2:0] OP_JMP = 3'o5;
  localparam logic [2:0] OP_IOT = 3'o6;
  localparam logic [2:0] OP_OPR = 3'o7;

  localparam logic [DATA_WIDTH-1:0] OP7_IAC     = 12'o7001;
  localparam logic [DATA_WIDTH-1:0] OP7_RAL     = 12'o7004;
  localparam logic [DATA_WIDTH-1:0] OP7_RTL     = 12'o7006;
  localparam logic [DATA_WIDTH-1:0] OP7_RAR     = 12'o7010;
  localparam logic [DATA_WIDTH-1:0] OP7_RTR     = 12'o7012;
  localparam logic [DATA_WIDTH-1:0] OP7_CML     = 12'o7020;
  localparam logic [DATA_WIDTH-1:0] OP7_CMA     = 12'o7040;
  localparam logic [DATA_WIDTH-1:0] OP7_CIA     = 12'o7041;
  localparam logic [DATA_WIDTH-1:0] OP7_CLL     = 12'o7100;
  localparam logic [DATA_WIDTH-1:0] OP7_CLA1    = 12'o7200;
  localparam logic [DATA_WIDTH-1:0] OP7_CLA_CLL = 12'o7300;
  localparam logic [DATA_WIDTH-1:0] OP7_HLT     = 12'o7402;
  localparam logic [DATA_WIDTH-1:0] OP7_OSR     = 12'o7404;
  localparam logic [DATA_WIDTH-1:0] OP7_SKP     = 12'o7410;
  localparam logic [DATA_WIDTH-1:0] OP7_SNL     = 12'o7420;
  localparam logic [DATA_WIDTH-1:0] OP7_SZL     = 12'o7430;
  localparam logic [DATA_WIDTH-1:0] OP7_SZA     = 12'o7440;
  localparam logic [DATA_WIDTH-1:0] OP7_SNA     = 12'o7450;
  localparam logic [DATA_WIDTH-1:0] OP7_SMA     = 12'o7500;
  localparam logic [DATA_WIDTH-1:0] OP7_SPA     = 12'o7510;
  localparam logic [DATA_WIDTH-1:0] OP7_CLA2    = 12'o7600;

  typedef struct packed {
    logic       AND;
    logic       TAD;
    logic       ISZ;
    logic       DCA;
    logic       JMS;
    logic       JMP;
    logic [8:0] mem_inst_addr;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic NOP;
    logic IAC;
    logic RAL;
    logic RTL;
    logic RAR;
    logic RTR;
    logic CML;
    logic CMA;
    logic CIA;
    logic CLL;
    logic CLA1;
    logic CLA_CLL;
    logic HLT;
    logic OSR;
    logic SKP;
    logic SNL;
    logic SZL;
    logic SZA;
    logic SNA;
    logic SMA;
    logic SPA;
    logic CLA2;
  } pdp_op7_opcode_s;

endpackage

// File: rtl/instr_fetch_decode_pdp_op_decode.sv
// Combinational PDP-8 instruction decoder.
//  word_i : 12-bit instruction word
//  mem_o  : one-hot memory-reference opcode plus 9-bit address field
//  op7_o  : one-hot operate opcode (NOP for IOT and unrecognised 7xxx)
// Exactly one opcode bit is set for every input. Unknown bits in the
// opcode field fall through to the default arm and decode as NOP.
module pdp_op_decode
  import instr_fetch_decode_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] word_i,
  output pdp_mem_opcode_s       mem_o,
  output pdp_op7_opcode_s       op7_o
);

  always_comb begin
    mem_o = '0;
    op7_o = '0;
    case (word_i[11:9])
      OP_AND: begin mem_o.AND = 1'b1; mem_o.mem_inst_addr = word_i[8:0]; end
      OP_TAD: begin mem_o.TAD = 1'b1; mem_o.mem_inst_addr = word_i[8:0]; end
      OP_ISZ: begin mem_o.ISZ = 1'b1; mem_o.mem_inst_addr = word_i[8:0]; end
      OP_DCA: begin mem_o.DCA = 1'b1; mem_o.mem_inst_addr = word_i[8:0]; end
      OP_JMS: begin mem_o.JMS = 1'b1; mem_o.mem_inst_addr = word_i[8:0]; end
      OP_JMP: begin mem_o.JMP = 1'b1; mem_o.mem_inst_addr = word_i[8:0]; end
      OP_IOT: op7_o.NOP = 1'b1;
      OP_OPR: begin
        // Only exact microcoded combinations are supported.
        case (word_i)
          OP7_IAC:     op7_o.IAC     = 1'b1;
          OP7_RAL:     op7_o.RAL     = 1'b1;
          OP7_RTL:     op7_o.RTL     = 1'b1;
          OP7_RAR:     op7_o.RAR     = 1'b1;
          OP7_RTR:     op7_o.RTR     = 1'b1;
          OP7_CML:     op7_o.CML     = 1'b1;
          OP7_CMA:     op7_o.CMA     = 1'b1;
          OP7_CIA:     op7_o.CIA     = 1'b1;
          OP7_CLL:     op7_o.CLL     = 1'b1;
          OP7_CLA1:    op7_o.CLA1    = 1'b1;
          OP7_CLA_CLL: op7_o.CLA_CLL = 1'b1;
          OP7_HLT:     op7_o.HLT     = 1'b1;
          OP7_OSR:     op7_o.OSR     = 1'b1;
          OP7_SKP:     op7_o.SKP     = 1'b1;
          OP7_SNL:     op7_o.SNL     = 1'b1;
          OP7_SZL:     op7_o.SZL     = 1'b1;
          OP7_SZA:     op7_o.SZA     = 1'b1;
          OP7_SNA:     op7_o.SNA     = 1'b1;
          OP7_SMA:     op7_o.SMA     = 1'b1;
          OP7_SPA:     op7_o.SPA     = 1'b1;
          OP7_CLA2:    op7_o.CLA2    = 1'b1;
          default:     op7_o.NOP     = 1'b1;
        endcase
      end
      default: op7_o.NOP = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// PDP-8 instruction fetch/decode unit.
//  clk, reset_n     : clock, asynchronous active-low reset
//  ifu_rd_req       : one-cycle read request per instruction
//  ifu_rd_addr      : fetch address, valid only while ifu_rd_req is high
//  ifu_rd_data      : instruction word, sampled RD_LATENCY cycles after the request
//  base_addr        : constant START_ADDR
//  pdp_mem_opcode   : registered one-hot memory-reference opcode
//  pdp_op7_opcode   : registered one-hot operate opcode
//  stall            : exec unit busy; only honoured while the opcode is presented
//  PC_value         : next fetch address from the exec unit
// Instruction cycle: FETCH, RD_LATENCY x WAIT, DECODE, EXEC (>=1), CLEAR.
module instr_fetch_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter int                    RD_LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = START_ADDRESS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  ifu_rd_req,
  output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  input  logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic [ADDR_WIDTH-1:0] base_addr,
  output pdp_mem_opcode_s       pdp_mem_opcode,
  output pdp_op7_opcode_s       pdp_op7_opcode,
  input  logic                  stall,
  input  logic [ADDR_WIDTH-1:0] PC_value
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_EXEC, S_CLEAR, S_HALT
  } state_e;

  localparam logic [2:0] LAST_CNT = 3'(RD_LATENCY - 1);

  state_e                state_q, state_d;
  logic                  first_q, first_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  pdp_mem_opcode_s       mem_q, mem_d;
  pdp_op7_opcode_s       op7_q, op7_d;
  pdp_mem_opcode_s       dec_mem;
  pdp_op7_opcode_s       dec_op7;

  pdp_op_decode u_decode (
    .word_i (instr_q),
    .mem_o  (dec_mem),
    .op7_o  (dec_op7)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      first_q <= 1'b1;
      cnt_q   <= '0;
      instr_q <= '0;
      mem_q   <= '0;
      op7_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      mem_q   <= mem_d;
      op7_q   <= op7_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    cnt_d       = cnt_q;
    instr_d     = instr_q;
    mem_d       = mem_q;
    op7_d       = op7_q;
    ifu_rd_req  = 1'b0;
    ifu_rd_addr = '0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        // Request and address decode straight from the state register, so
        // the address is driven only for the single request cycle.
        ifu_rd_req  = 1'b1;
        ifu_rd_addr = first_q ? START_ADDR : PC_value;
        first_d     = 1'b0;
        cnt_d       = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == LAST_CNT) begin
          instr_d = ifu_rd_data;
          cnt_d   = '0;
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DECODE: begin
        mem_d   = dec_mem;
        op7_d   = dec_op7;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // The EXEC cycle itself is the mandatory hold; leave on the first
        // cycle the exec unit is not stalling. Opcodes are zeroed on the way
        // out so they read zero throughout CLEAR/HALT.
        if (!stall) begin
          mem_d   = '0;
          op7_d   = '0;
          state_d = op7_q.HLT ? S_HALT : S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign base_addr      = START_ADDR;
  assign pdp_mem_opcode = mem_q;
  assign pdp_op7_opcode = op7_q;

endmodule
